// File: rtl/datamover_cmd_arb.sv
// Round-robin arbiter that turns per-channel move requests into DataMover commands and routes status back.
// Latency: request seen in IDLE at N -> tvalid at N+1 -> ack at N+2 (zero-length requests ack at N+1).
// Backpressure: tdata held stable while tready is low; new grants held off at MAX_OUT outstanding.
module datamover_cmd_arb #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int BTT_W   = 23,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk_dma,
  input  logic                     rst_dma,
  input  logic [NUM_CH-1:0]        i_cmd_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_cmd_addr,
  input  logic [NUM_CH*BTT_W-1:0]  i_cmd_btt,
  output logic [NUM_CH-1:0]        o_cmd_ack,
  output logic                     o_cmd_tvalid,
  input  logic                     i_cmd_tready,
  output logic [ADDR_W+39:0]       o_cmd_tdata,
  input  logic                     i_sts_tvalid,
  output logic                     o_sts_tready,
  input  logic [7:0]               i_sts_tdata,
  output logic [NUM_CH-1:0]        o_done,
  output logic [NUM_CH-1:0]        o_err,
  output logic                     o_tag_err,
  output logic [3:0]               o_outstanding
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  // DataMover command word, MSB first
  typedef struct packed {
    logic [3:0]        rsvd;
    logic [3:0]        tag;
    logic [ADDR_W-1:0] addr;
    logic              drr;
    logic              eof;
    logic [5:0]        dsa;
    logic              incr;
    logic [22:0]       btt;
  } cmd_t;

  logic [1:0]        state_q, state_d;
  logic [3:0]        grant_q;
  logic [3:0]        rr_q;
  logic              zero_q;
  cmd_t              cmd_q, cmd_d;
  logic [3:0]        out_q;
  logic [NUM_CH-1:0] done_q, sts_err_q;
  logic              tag_err_q;

  logic              found;
  logic [3:0]        pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [BTT_W-1:0]  sel_btt;
  logic              can_grant, zero_btt, cmd_hs;
  logic              sts_hs, tag_ok, sts_ok, dec;
  logic [3:0]        sts_tag;
  logic [NUM_CH-1:0] sts_vec, ack_vec;

  // Round-robin search: first requester at or above the pointer, else the lowest one (wrap)
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && i_cmd_req[c] && (4'(c) >= rr_q)) begin
        found = 1'b1;
        pick  = 4'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && i_cmd_req[c]) begin
        found = 1'b1;
        pick  = 4'(c);
      end
    end
  end

  // Select the picked channel's address and byte count
  always_comb begin
    sel_addr = '0;
    sel_btt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick == 4'(c)) begin
        sel_addr = i_cmd_addr[c*ADDR_W +: ADDR_W];
        sel_btt  = i_cmd_btt[c*BTT_W +: BTT_W];
      end
    end
  end

  // Assemble the command word for the picked channel
  always_comb begin
    cmd_d      = '0;
    cmd_d.btt  = 23'(sel_btt);
    cmd_d.incr = 1'b1;
    cmd_d.eof  = 1'b1;
    cmd_d.addr = sel_addr;
    cmd_d.tag  = pick;
  end

  assign can_grant = (state_q == IDLE) && found && (out_q < 4'(MAX_OUT));
  assign zero_btt  = (sel_btt == '0);
  assign cmd_hs    = (state_q == ISSUE) && i_cmd_tready;

  // Next-state logic; zero-length requests skip the command stream entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (can_grant) state_d = zero_btt ? ACK : ISSUE;
      ISSUE:   if (i_cmd_tready) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture grant, advance round-robin pointer and latch the command word on each grant
  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) begin
      grant_q <= '0;
      rr_q    <= '0;
      zero_q  <= 1'b0;
      cmd_q   <= '0;
    end else if (can_grant) begin
      grant_q <= pick;
      rr_q    <= (pick == 4'(NUM_CH-1)) ? 4'd0 : pick + 4'd1;
      zero_q  <= zero_btt;
      cmd_q   <= cmd_d;
    end
  end

  // Status decode; a valid tag only retires a command when one is actually in flight
  assign sts_hs  = i_sts_tvalid && o_sts_tready;
  assign sts_tag = i_sts_tdata[3:0];
  assign tag_ok  = (32'(sts_tag) < NUM_CH);
  assign sts_ok  = i_sts_tdata[7] && (i_sts_tdata[6:4] == 3'b000);
  assign dec     = sts_hs && tag_ok && (out_q != 4'd0);

  // One-hot of the status tag and of the channel being acknowledged
  always_comb begin
    sts_vec = '0;
    ack_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sts_vec[c] = sts_hs && tag_ok && (sts_tag == 4'(c));
      ack_vec[c] = (state_q == ACK) && (grant_q == 4'(c));
    end
  end

  // Outstanding counter: saturates at both ends, simultaneous issue and retire cancel out
  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) begin
      out_q <= '0;
    end else begin
      case ({cmd_hs, dec})
        2'b10:   if (out_q < 4'(MAX_OUT)) out_q <= out_q + 4'd1;
        2'b01:   out_q <= out_q - 4'd1;
        default: out_q <= out_q;
      endcase
    end
  end

  // Completion pulses one cycle after the status handshake; sticky flag for unexpected status
  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) begin
      done_q    <= '0;
      sts_err_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      done_q    <= sts_ok ? sts_vec : '0;
      sts_err_q <= sts_ok ? '0 : sts_vec;
      if (sts_hs && (!tag_ok || (out_q == 4'd0))) tag_err_q <= 1'b1;
    end
  end

  assign o_cmd_tvalid  = (state_q == ISSUE);
  assign o_cmd_tdata   = cmd_q;
  assign o_cmd_ack     = ack_vec;
  assign o_done        = done_q;
  assign o_err         = sts_err_q | (zero_q ? ack_vec : '0);
  assign o_tag_err     = tag_err_q;
  assign o_outstanding = out_q;
  assign o_sts_tready  = ~rst_dma;

endmodule

// File: tb/tb_datamover_cmd_arb.sv
// Directed bench for datamover_cmd_arb with NUM_CH=2, ADDR_W=32, BTT_W=23, MAX_OUT=4.
// Latency: inputs driven and outputs sampled on the falling edge of clk_dma.
// Backpressure: tready held low and toggled by the stimulus to exercise stalls.
module tb_datamover_cmd_arb;

  logic        clk_dma = 1'b0;
  logic        rst_dma = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] addr = '0;
  logic [45:0] btt = '0;
  logic [1:0]  ack;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [71:0] tdata;
  logic        sts_tvalid = 1'b0;
  logic        sts_tready;
  logic [7:0]  sts_tdata = '0;
  logic [1:0]  done, err;
  logic        tag_err;
  logic [3:0]  outstanding;

  int total = 0;
  int bad = 0;

  datamover_cmd_arb #(.NUM_CH(2), .ADDR_W(32), .BTT_W(23), .MAX_OUT(4)) dut (
    .clk_dma      (clk_dma),
    .rst_dma      (rst_dma),
    .i_cmd_req    (req),
    .i_cmd_addr   (addr),
    .i_cmd_btt    (btt),
    .o_cmd_ack    (ack),
    .o_cmd_tvalid (tvalid),
    .i_cmd_tready (tready),
    .o_cmd_tdata  (tdata),
    .i_sts_tvalid (sts_tvalid),
    .o_sts_tready (sts_tready),
    .i_sts_tdata  (sts_tdata),
    .o_done       (done),
    .o_err        (err),
    .o_tag_err    (tag_err),
    .o_outstanding(outstanding)
  );

  always #5 clk_dma = ~clk_dma;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_dma);
  endtask

  task automatic wait_tvalid();
    int n;
    n = 0;
    while (!tvalid && n < 20) begin
      step();
      n++;
    end
    chk("tvalid_seen", 72'(tvalid), 72'd1);
  endtask

  task automatic send_cmd(input int ch, input logic [31:0] a, input logic [22:0] b);
    int n;
    addr[ch*32 +: 32] = a;
    btt[ch*23 +: 23]  = b;
    req[ch] = 1'b1;
    n = 0;
    while (!ack[ch] && n < 20) begin
      step();
      n++;
    end
    chk("send_ack_seen", 72'(ack[ch]), 72'd1);
    req[ch] = 1'b0;
    step();
  endtask

  initial begin
    int g;
    // reset state
    step();
    step();
    chk("rst_tvalid", 72'(tvalid), 72'd0);
    chk("rst_outstanding", 72'(outstanding), 72'd0);
    chk("rst_sts_tready", 72'(sts_tready), 72'd0);
    chk("rst_tdata", tdata, 72'd0);
    chk("rst_tag_err", 72'(tag_err), 72'd0);
    chk("rst_ack", 72'(ack), 72'd0);
    rst_dma = 1'b0;
    step();
    chk("sts_tready_up", 72'(sts_tready), 72'd1);

    // single command on ch0, minimum latency
    addr[31:0] = 32'h1000_0000;
    btt[22:0]  = 23'd256;
    req = 2'b01;
    step();
    chk("t1_tvalid_n1", 72'(tvalid), 72'd1);
    chk("t1_tdata", tdata, {8'h00, 32'h1000_0000, 32'h4080_0100});
    chk("t1_ack_n1", 72'(ack), 72'd0);
    step();
    chk("t1_ack_n2", 72'(ack), 72'd1);
    chk("t1_outstanding", 72'(outstanding), 72'd1);
    chk("t1_tvalid_n2", 72'(tvalid), 72'd0);
    req = 2'b00;
    sts_tvalid = 1'b1;
    sts_tdata  = 8'h80;
    step();
    sts_tvalid = 1'b0;
    chk("t1_done", 72'(done), 72'd1);
    chk("t1_out_retired", 72'(outstanding), 72'd0);
    step();
    chk("t1_done_pulse", 72'(done), 72'd0);

    // round-robin alternation from a fresh reset
    rst_dma = 1'b1;
    step();
    rst_dma = 1'b0;
    addr = {32'h3000_0000, 32'h2000_0000};
    btt  = {23'd64, 23'd32};
    req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      wait_tvalid();
      chk("rr_tag", 72'(tdata[67:64]), 72'(g));
      step();
      chk("rr_ack", 72'(ack), 72'(1 << g));
      req[g] = 1'b0;
      sts_tvalid = 1'b1;
      sts_tdata  = 8'h80 | 8'(g);
      step();
      sts_tvalid = 1'b0;
      req[g] = 1'b1;
    end
    req = 2'b00;
    step();
    step();
    step();
    chk("rr_out_drained", 72'(outstanding), 72'd0);

    // fill to MAX_OUT, stall, then release with a status
    send_cmd(0, 32'h0000_0100, 23'd16);
    send_cmd(1, 32'h0000_0200, 23'd16);
    send_cmd(0, 32'h0000_0300, 23'd16);
    send_cmd(1, 32'h0000_0400, 23'd16);
    chk("full_outstanding", 72'(outstanding), 72'd4);
    addr[31:0] = 32'h0000_0500;
    req = 2'b01;
    step();
    step();
    step();
    step();
    chk("full_stalled", 72'(tvalid), 72'd0);
    chk("full_still4", 72'(outstanding), 72'd4);
    sts_tvalid = 1'b1;
    sts_tdata  = 8'h81;
    step();
    sts_tvalid = 1'b0;
    chk("rel_done1", 72'(done), 72'd2);
    chk("rel_out3", 72'(outstanding), 72'd3);
    step();
    chk("rel_tvalid", 72'(tvalid), 72'd1);
    chk("rel_tag", 72'(tdata[67:64]), 72'd0);
    step();
    chk("rel_ack", 72'(ack), 72'd1);
    chk("rel_out4", 72'(outstanding), 72'd4);
    req = 2'b00;
    step();

    // error status, drain, then an unexpected tag
    sts_tvalid = 1'b1;
    sts_tdata  = 8'hC0;
    step();
    sts_tvalid = 1'b0;
    chk("err_pulse", 72'(err), 72'd1);
    chk("err_no_done", 72'(done), 72'd0);
    chk("err_out3", 72'(outstanding), 72'd3);
    sts_tvalid = 1'b1;
    sts_tdata  = 8'h81;
    step();
    step();
    step();
    sts_tvalid = 1'b0;
    chk("drain_out0", 72'(outstanding), 72'd0);
    chk("drain_no_tag_err", 72'(tag_err), 72'd0);
    sts_tvalid = 1'b1;
    sts_tdata  = 8'h87;
    step();
    sts_tvalid = 1'b0;
    chk("tag7_flag", 72'(tag_err), 72'd1);
    chk("tag7_no_err", 72'(err), 72'd0);
    chk("tag7_no_done", 72'(done), 72'd0);
    chk("tag7_out0", 72'(outstanding), 72'd0);
    step();
    step();
    step();
    chk("tag_err_sticky", 72'(tag_err), 72'd1);

    // zero-length request on ch1
    btt[45:23] = 23'd0;
    req = 2'b10;
    step();
    chk("z_tvalid", 72'(tvalid), 72'd0);
    chk("z_ack", 72'(ack), 72'd2);
    chk("z_err", 72'(err), 72'd2);
    chk("z_out", 72'(outstanding), 72'd0);
    req = 2'b00;
    step();
    chk("z_ack_pulse", 72'(ack), 72'd0);
    chk("z_err_pulse", 72'(err), 72'd0);

    // backpressure with max btt, then reset mid-ISSUE
    tready = 1'b0;
    addr[31:0] = 32'h2000_0040;
    btt[22:0]  = 23'h7F_FFFF;
    req = 2'b01;
    step();
    chk("bp_tvalid", 72'(tvalid), 72'd1);
    chk("bp_tdata", tdata, {8'h00, 32'h2000_0040, 32'h40FF_FFFF});
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_tvalid", 72'(tvalid), 72'd1);
      chk("bp_hold_tdata", tdata, {8'h00, 32'h2000_0040, 32'h40FF_FFFF});
    end
    rst_dma = 1'b1;
    #1;
    chk("mid_rst_tvalid", 72'(tvalid), 72'd0);
    chk("mid_rst_out", 72'(outstanding), 72'd0);
    chk("mid_rst_tdata", tdata, 72'd0);
    step();
    chk("mid_rst_no_ack", 72'(ack), 72'd0);
    rst_dma = 1'b0;
    tready = 1'b1;
    btt[45:23] = 23'd8;
    req = 2'b11;
    step();
    chk("rerq_tvalid", 72'(tvalid), 72'd1);
    chk("rerq_tag0", 72'(tdata[67:64]), 72'd0);
    chk("rerq_tag_err_clr", 72'(tag_err), 72'd0);
    step();
    chk("rerq_ack", 72'(ack), 72'd1);
    req = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
